bp_mem_cmd_responder: RTL and testbench



---
 rtl/bp_mem_cmd_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_bp_mem_cmd_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bp_mem_cmd_responder.sv
// bp_mem_cmd_responder
//   Single-outstanding memory command responder backed by a block-wide store.
//   A command is consumed in IDLE (valid->yumi). Writes update the store on
//   the acceptance cycle, and reads are captured on that same cycle. The
//   response is presented latency_p cycles after acceptance and is held until
//   the ready&valid handshake.
//
//   Message layout (MSB..LSB): msg_type[3:0], addr[paddr_width_p-1:0],
//   size[2:0], payload[15:0], data[cce_block_width_p-1:0].
//
//   Ports
//     clk_i             sole clock
//     reset_n_i         asynchronous active-low reset
//     mem_cmd_i         command message
//     mem_cmd_v_i       command valid
//     mem_cmd_yumi_o    command consumed this cycle
//     mem_resp_o        response message (latched header + response data)
//     mem_resp_v_o      response valid
//     mem_resp_ready_i  downstream ready
//
//   Build option
//     BP_MEM_RESPONDER_ADDR_CHECK_EN  When defined, a block index >= mem_els_p
//                                     drops the write and returns all-ones
//                                     data. When undefined, indices wrap
//                                     modulo mem_els_p.

module bp_mem_cmd_responder
  #(localparam int e_bp_inv_cfg       = 0
  , localparam int e_bp_half_line_cfg = 1
  , parameter  int bp_params_p        = e_bp_inv_cfg
  , parameter  int unsigned mem_els_p = 64
  , parameter  int unsigned latency_p = 4
  , localparam int unsigned paddr_width_p            = 40
  , localparam int unsigned cce_block_width_p        = (bp_params_p == e_bp_half_line_cfg) ? 256 : 512
  , localparam int unsigned cce_mem_payload_width_lp = 16
  , localparam int unsigned cce_mem_msg_width_lp     = 4 + paddr_width_p + 3
                                                     + cce_mem_payload_width_lp + cce_block_width_p
  )
  (input  logic                            clk_i
  , input  logic                            reset_n_i
  , input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i
  , input  logic                            mem_cmd_v_i
  , output logic                            mem_cmd_yumi_o
  , output logic [cce_mem_msg_width_lp-1:0] mem_resp_o
  , output logic                            mem_resp_v_o
  , input  logic                            mem_resp_ready_i
  );

  localparam int unsigned blk_bytes_lp = cce_block_width_p / 8;
  localparam int unsigned offset_w_lp  = $clog2(blk_bytes_lp);
  localparam int unsigned blk_num_w_lp = paddr_width_p - offset_w_lp;
  localparam int unsigned idx_w_lp     = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
  localparam int unsigned cnt_w_lp     = (latency_p > 0) ? $clog2(latency_p + 1) : 1;
  localparam logic [blk_num_w_lp-1:0] mem_els_lp = blk_num_w_lp'(mem_els_p);

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3
  } msg_type_e;

  typedef struct packed {
    logic [3:0]                          msg_type;
    logic [paddr_width_p-1:0]            addr;
    logic [2:0]                          size;
    logic [cce_mem_payload_width_lp-1:0] payload;
  } hdr_s;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  // Command decode
  hdr_s                         cmd_hdr;
  logic [cce_block_width_p-1:0] cmd_data;
  logic [blk_num_w_lp-1:0]      blk_num;
  logic [offset_w_lp-1:0]       blk_off;
  logic [idx_w_lp-1:0]          blk_idx;
  logic                         in_range;

  assign cmd_hdr  = mem_cmd_i[cce_mem_msg_width_lp-1 -: $bits(hdr_s)];
  assign cmd_data = mem_cmd_i[cce_block_width_p-1:0];
  assign blk_num  = cmd_hdr.addr[paddr_width_p-1:offset_w_lp];
  assign blk_off  = cmd_hdr.addr[offset_w_lp-1:0];
  assign blk_idx  = idx_w_lp'(blk_num % mem_els_lp);

`ifdef BP_MEM_RESPONDER_ADDR_CHECK_EN
  assign in_range = (blk_num < mem_els_lp);
`else
  assign in_range = 1'b1;
`endif

  // State
  state_e                       state_r;
  logic [cnt_w_lp-1:0]          cnt_r;
  logic                         resp_v_r;
  hdr_s                         hdr_r;
  logic [cce_block_width_p-1:0] data_r;
  logic                         yumi;

  // Reset is folded in so that no consume is signalled while held in reset.
  assign yumi           = reset_n_i & mem_cmd_v_i & (state_r == IDLE);
  assign mem_cmd_yumi_o = yumi;
  assign mem_resp_v_o   = resp_v_r;
  assign mem_resp_o     = {hdr_r, data_r};

  // Backing store (not reset)
  logic [cce_block_width_p-1:0] mem [mem_els_p];
  logic [cce_block_width_p-1:0] rd_block;

  assign rd_block = mem[blk_idx];

  // Uncached access: size capped at one dword, bytes placed at the addr byte
  // offset; lanes that would fall past the end of the block are dropped.
  logic [1:0]                   uc_size;
  logic [blk_bytes_lp-1:0]      uc_len_mask;
  logic [blk_bytes_lp-1:0]      uc_byte_mask;
  logic [cce_block_width_p-1:0] uc_len_bits;
  logic [cce_block_width_p-1:0] uc_bit_mask;
  logic [cce_block_width_p-1:0] uc_wdata;
  logic [cce_block_width_p-1:0] uc_rdata;

  assign uc_size      = (cmd_hdr.size > 3'd3) ? 2'd3 : cmd_hdr.size[1:0];
  assign uc_len_mask  = blk_bytes_lp'((16'd1 << (5'd1 << uc_size)) - 16'd1);
  assign uc_byte_mask = uc_len_mask << blk_off;
  assign uc_wdata     = cmd_data << {blk_off, 3'b000};
  assign uc_rdata     = (rd_block >> {blk_off, 3'b000}) & uc_len_bits;

  always_comb begin
    uc_len_bits = '0;
    uc_bit_mask = '0;
    for (int unsigned i = 0; i < blk_bytes_lp; i++) begin
      uc_len_bits[8*i +: 8] = {8{uc_len_mask[i]}};
      uc_bit_mask[8*i +: 8] = {8{uc_byte_mask[i]}};
    end
  end

  // Per-type write enable/mask and response data
  logic                         wr_en;
  logic [cce_block_width_p-1:0] wr_mask;
  logic [cce_block_width_p-1:0] wr_data;
  logic [cce_block_width_p-1:0] resp_data;
  logic                         known_type;

  always_comb begin
    wr_en      = 1'b0;
    wr_mask    = '0;
    wr_data    = '0;
    resp_data  = '0;
    known_type = 1'b1;
    case (cmd_hdr.msg_type)
      e_cce_mem_rd:    resp_data = rd_block;
      e_cce_mem_uc_rd: resp_data = uc_rdata;
      e_cce_mem_wr: begin
        wr_en   = yumi & in_range;
        wr_mask = '1;
        wr_data = cmd_data;
      end
      e_cce_mem_uc_wr: begin
        wr_en   = yumi & in_range;
        wr_mask = uc_bit_mask;
        wr_data = uc_wdata;
      end
      default: known_type = 1'b0;
    endcase
    if (known_type && !in_range) begin
      resp_data = '1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[blk_idx] <= (mem[blk_idx] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  // Control FSM
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      resp_v_r <= 1'b0;
      hdr_r    <= '0;
      data_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (yumi) begin
            hdr_r  <= cmd_hdr;
            data_r <= resp_data;
            cnt_r  <= cnt_w_lp'(latency_p);
            if (latency_p == 0) begin
              state_r  <= RESP;
              resp_v_r <= 1'b1;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - cnt_w_lp'(1);
          if (cnt_r == cnt_w_lp'(1)) begin
            state_r  <= RESP;
            resp_v_r <= 1'b1;
          end
        end
        RESP: begin
          if (mem_resp_ready_i) begin
            state_r  <= IDLE;
            resp_v_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          resp_v_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_mem_cmd_responder.sv
// Directed bench for bp_mem_cmd_responder: one instance with latency 2 and a
// 16-block store, one with latency 0 and the default store size.
module tb_bp_mem_cmd_responder;

  localparam int unsigned PADDR = 40;
  localparam int unsigned BLK   = 512;
  localparam int unsigned PAY   = 16;
  localparam int unsigned MSG   = 4 + PADDR + 3 + PAY + BLK;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [MSG-1:0] a_cmd, a_resp, b_cmd, b_resp;
  logic a_v, a_yumi, a_resp_v, a_ready;
  logic b_v, b_yumi, b_resp_v, b_ready;

  int checks = 0;
  int errors = 0;

  bp_mem_cmd_responder #(.mem_els_p(16), .latency_p(2)) u_dut_a (
    .clk_i(clk), .reset_n_i(rst_n),
    .mem_cmd_i(a_cmd), .mem_cmd_v_i(a_v), .mem_cmd_yumi_o(a_yumi),
    .mem_resp_o(a_resp), .mem_resp_v_o(a_resp_v), .mem_resp_ready_i(a_ready));

  bp_mem_cmd_responder #(.mem_els_p(64), .latency_p(0)) u_dut_b (
    .clk_i(clk), .reset_n_i(rst_n),
    .mem_cmd_i(b_cmd), .mem_cmd_v_i(b_v), .mem_cmd_yumi_o(b_yumi),
    .mem_resp_o(b_resp), .mem_resp_v_o(b_resp_v), .mem_resp_ready_i(b_ready));

  task automatic check(input string tag, input logic [MSG-1:0] obs, input logic [MSG-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MSG-1:0] mk(input logic [3:0] t, input logic [PADDR-1:0] a,
                                        input logic [2:0] sz, input logic [PAY-1:0] p,
                                        input logic [BLK-1:0] d);
    return {t, a, sz, p, d};
  endfunction

  // Present a command on A and return #1 after the edge that accepts it.
  task automatic a_issue(input logic [MSG-1:0] c, input string tag);
    int n;
    @(negedge clk);
    a_cmd = c;
    a_v   = 1'b1;
    #1;
    n = 0;
    while (!a_yumi && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_yumi"}, MSG'(a_yumi), MSG'(1));
    @(posedge clk); #1;
    a_v = 1'b0;
  endtask

  // Count edges after acceptance until response valid appears.
  task automatic a_wait_resp(input string tag, input int exp_edges);
    int e;
    e = 0;
    while (!a_resp_v && e < 50) begin
      @(posedge clk); #1; e++;
    end
    check({tag, "_v"}, MSG'(a_resp_v), MSG'(1));
    check({tag, "_lat"}, MSG'(e), MSG'(exp_edges));
  endtask

  task automatic a_txn(input logic [MSG-1:0] c, input logic [BLK-1:0] exp_data, input string tag);
    a_issue(c, tag);
    a_wait_resp(tag, 2);
    check({tag, "_resp"}, a_resp, {c[MSG-1:BLK], exp_data});
    @(posedge clk); #1;
    check({tag, "_drop"}, MSG'(a_resp_v), MSG'(0));
  endtask

  logic [BLK-1:0] a5, exp_blk, p4, p20, exp_wr20, exp_rd20, exp_rd4;
  logic [MSG-1:0] c_hold;
  logic           seen;

  initial begin
    rst_n = 1'b0; a_v = 1'b0; b_v = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    a_cmd = '0; b_cmd = '0;
    a5 = {64{8'hA5}};
    p4 = {64{8'h3C}};
    p20 = {64{8'hC3}};

    // Reset state, including no consume while held in reset
    @(negedge clk);
    a_v = 1'b1;
    #1;
    check("rst_yumi", MSG'(a_yumi), MSG'(0));
    check("rst_resp_v", MSG'(a_resp_v), MSG'(0));
    check("rst_resp", a_resp, '0);
    check("rst_b_resp_v", MSG'(b_resp_v), MSG'(0));
    a_v = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full block write and read back
    a_txn(mk(4'd1, 40'h40, 3'd6, 16'h0011, a5), '0, "wr40");
    a_txn(mk(4'd0, 40'h40, 3'd6, 16'h0022, '0), a5, "rd40");

    // Uncached dword write/read, then confirm only bytes 8..15 changed
    a_txn(mk(4'd3, 40'h48, 3'd3, 16'h0033, 512'h1122334455667788), '0, "ucwr48");
    a_txn(mk(4'd2, 40'h48, 3'd3, 16'h0044, '0), 512'h1122334455667788, "ucrd48");
    exp_blk = a5;
    exp_blk[127:64] = 64'h1122334455667788;
    a_txn(mk(4'd0, 40'h40, 3'd6, 16'h0055, '0), exp_blk, "rd40_uc");
    a_txn(mk(4'd2, 40'h4A, 3'd1, 16'h0066, '0), 512'h5566, "ucrd4a_h");
    a_txn(mk(4'd2, 40'h47, 3'd0, 16'h0077, '0), 512'hA5, "ucrd47_b");

    // Back-pressure: response held, no new consume while waiting
    a_ready = 1'b0;
    c_hold = mk(4'd0, 40'h40, 3'd6, 16'h0088, '0);
    a_issue(c_hold, "bp");
    a_wait_resp("bp", 2);
    a_cmd = mk(4'd2, 40'h48, 3'd3, 16'h0099, '0);
    a_v = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_v", MSG'(a_resp_v), MSG'(1));
      check("bp_hold_resp", a_resp, {c_hold[MSG-1:BLK], exp_blk});
      check("bp_hold_yumi", MSG'(a_yumi), MSG'(0));
    end
    @(negedge clk);
    a_ready = 1'b1;
    #1;
    check("hs_cycle_yumi", MSG'(a_yumi), MSG'(0));
    @(posedge clk); #1;
    check("hs_drop", MSG'(a_resp_v), MSG'(0));
    check("hs_next_yumi", MSG'(a_yumi), MSG'(1));
    @(posedge clk); #1;
    a_v = 1'b0;
    a_wait_resp("hs_next", 2);
    check("hs_next_resp", a_resp, {a_cmd[MSG-1:BLK], 512'h1122334455667788});
    @(posedge clk); #1;

    // Reset while waiting discards the pending response
    a_issue(mk(4'd0, 40'h40, 3'd6, 16'h00AA, '0), "rstw");
    #2 rst_n = 1'b0;
    #1;
    check("rstw_v", MSG'(a_resp_v), MSG'(0));
    check("rstw_resp", a_resp, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | a_resp_v;
    end
    check("rstw_noresp", MSG'(seen), MSG'(0));
    a_txn(mk(4'd0, 40'h40, 3'd6, 16'h00BB, '0), exp_blk, "rd_after_rst");

    // Out-of-range index 20 with a 16-block store
`ifdef BP_MEM_RESPONDER_ADDR_CHECK_EN
    exp_wr20 = '1;
    exp_rd20 = '1;
    exp_rd4  = p4;
`else
    exp_wr20 = '0;
    exp_rd20 = p20;
    exp_rd4  = p20;
`endif
    a_txn(mk(4'd1, 40'h100, 3'd6, 16'h0101, p4), '0, "wr_idx4");
    a_txn(mk(4'd1, 40'h500, 3'd6, 16'h0202, p20), exp_wr20, "wr_idx20");
    a_txn(mk(4'd0, 40'h500, 3'd6, 16'h0303, '0), exp_rd20, "rd_idx20");
    a_txn(mk(4'd0, 40'h100, 3'd6, 16'h0404, '0), exp_rd4, "rd_idx4");

    // Unrecognized type: consumed, data 0, store untouched
    a_txn(mk(4'd7, 40'h100, 3'd6, 16'h0505, {64{8'h77}}), '0, "unk");
    a_txn(mk(4'd0, 40'h100, 3'd6, 16'h0606, '0), exp_rd4, "rd_after_unk");

    // Zero latency, valid and ready held: yumi every 2nd cycle
    @(negedge clk);
    b_cmd = mk(4'd1, 40'h0, 3'd6, 16'h00B0, {64{8'h5A}});
    b_v = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("b_yumi_on", MSG'(b_yumi), MSG'(1));
      check("b_v_off", MSG'(b_resp_v), MSG'(0));
      @(negedge clk); #1;
      check("b_yumi_off", MSG'(b_yumi), MSG'(0));
      check("b_v_on", MSG'(b_resp_v), MSG'(1));
      check("b_resp", b_resp, {b_cmd[MSG-1:BLK], {BLK{1'b0}}});
      @(negedge clk); #1;
    end
    b_v = 1'b0;

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
